// File: rtl/store_lane_unit_pkg.sv
// ---------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store-path narrower: store size encodings,
// the control-state enum and the alignment check used when a request is
// accepted.
// ---------------------------------------------------------------------------
package store_pkg;

  // Store size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Control states of the store sequencer
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    FAULT = 2'b11
  } state_t;

  // A request is dropped when its size is illegal or its address is not a
  // multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_unit_if.sv
// ---------------------------------------------------------------------------
// store_lane_unit_if
// Bundles the store request handshake, the word-wide memory port and the
// completion/fault pulses.
//   slave  : the store unit (consumes requests, drives the memory port)
//   master : the environment (execute stage issuing stores + data memory)
// Signals:
//   req_valid/req_ready/req_size/req_addr/req_data : store request
//   mem_addr/mem_rd/mem_wr/mem_wdata              : memory command
//   mem_rdata/mem_ack                              : memory response
//   done/fault                                     : one-cycle status pulses
// ---------------------------------------------------------------------------
interface store_lane_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              done;
  logic              fault;

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_rdata, mem_ack,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, fault
  );

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_rdata, mem_ack,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, fault
  );
endinterface

// File: rtl/store_lane_merge.sv
// ---------------------------------------------------------------------------
// store_lane_merge
// Purely combinational big-endian lane insert. Places the low byte/half of
// the register value into the old memory word; all untouched bits keep the
// old word's value. A word store replaces the whole word.
// Ports:
//   i_size     : store size encoding
//   i_addr_lo  : byte address bits [1:0]
//   i_reg_data : source register value
//   i_old_word : word read back from memory
//   o_merged   : word to write back
// ---------------------------------------------------------------------------
module store_lane_merge
  import store_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_reg_data,
  input  logic [31:0] i_old_word,
  output logic [31:0] o_merged
);

  // Byte lane k sits at bits [31-8k:24-8k]; half lane 0 is the upper half
  always_comb begin
    o_merged = i_old_word;
    case (i_size)
      SZ_BYTE: begin
        case (i_addr_lo)
          2'd0:    o_merged[31:24] = i_reg_data[7:0];
          2'd1:    o_merged[23:16] = i_reg_data[7:0];
          2'd2:    o_merged[15:8]  = i_reg_data[7:0];
          default: o_merged[7:0]   = i_reg_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) begin
          o_merged[15:0] = i_reg_data[15:0];
        end else begin
          o_merged[31:16] = i_reg_data[15:0];
        end
      end
      SZ_WORD: o_merged = i_reg_data;
      default: o_merged = i_old_word;
    endcase
  end

endmodule

// File: rtl/store_lane_unit.sv
// ---------------------------------------------------------------------------
// store_lane_unit
// Store-path narrower for a memory without byte enables. Word stores are a
// single write; byte/half stores read the containing word, merge the lane
// and write it back. Misaligned or illegal requests are dropped with a
// one-cycle fault pulse and no memory access.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : request handshake, memory port and done/fault pulses
// All interface outputs are driven from registers.
// ---------------------------------------------------------------------------
module store_lane_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  store_lane_unit_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_size;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_data;
  logic              r_req_ready, w_ready_nxt;
  logic              r_mem_rd,    w_rd_nxt;
  logic              r_mem_wr,    w_wr_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
  logic [31:0]       r_mem_wdata, w_wdata_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_fault,     w_fault_nxt;
  logic              w_capture;
  logic [31:0]       w_merged;

  store_lane_merge u_merge (
    .i_size     (r_size),
    .i_addr_lo  (r_addr_lo),
    .i_reg_data (r_data),
    .i_old_word (bus.mem_rdata),
    .o_merged   (w_merged)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every strobe and pulse leaves the block from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_req_ready;
    w_rd_nxt    = r_mem_rd;
    w_wr_nxt    = r_mem_wr;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_done_nxt  = 1'b0;
    w_fault_nxt = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_nxt = 1'b1;
        if (bus.req_valid && r_req_ready) begin
          w_capture   = 1'b1;
          w_ready_nxt = 1'b0;
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
          end else if (bus.req_size == SZ_WORD) begin
            w_state_nxt = WRITE;
            w_wr_nxt    = 1'b1;
            w_addr_nxt  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            w_wdata_nxt = bus.req_data;
          end else begin
            w_state_nxt = READ;
            w_rd_nxt    = 1'b1;
            w_addr_nxt  = {bus.req_addr[ADDR_W-1:2], 2'b00};
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        // Address is held; only the strobe flips from read to write
        if (bus.mem_ack) begin
          w_state_nxt = WRITE;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b1;
          w_wdata_nxt = w_merged;
        end else begin
          w_state_nxt = READ;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          w_state_nxt = IDLE;
          w_wr_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = WRITE;
        end
      end
      FAULT: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    endcase
  end

  // State, output and request-capture registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 32'h0000_0000;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_addr_lo   <= 2'b00;
      r_data      <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_ready_nxt;
      r_mem_rd    <= w_rd_nxt;
      r_mem_wr    <= w_wr_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_done      <= w_done_nxt;
      r_fault     <= w_fault_nxt;
      if (w_capture) begin
        r_size    <= bus.req_size;
        r_addr_lo <= bus.req_addr[1:0];
        r_data    <= bus.req_data;
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_store_lane_unit.sv
// ---------------------------------------------------------------------------
// tb_store_lane_unit
// Drives store requests into store_lane_unit against a behavioural word
// memory with programmable ack delays. Expected memory contents, access
// sequences and latencies come from an arithmetic mask/shift model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_store_lane_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  store_lane_unit_if #(.ADDR_W(32)) bus_if ();

  store_lane_unit #(.ADDR_W(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic [31:0] mem [int];
  acc_t        log_q[$];
  int          done_q[$];
  int          rd_dly = 0;
  int          wr_dly = 0;
  int          wait_cnt = 0;
  int          rd_cycles = 0;
  int          overlap = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory word at a byte address; untouched words hold an address pattern
  function automatic logic [31:0] peek(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (mem.exists(k)) return mem[k];
    return a ^ 32'hA5C3_0F96;
  endfunction

  // Reference: mask out the target lane, insert the shifted source bits
  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] data);
    int sh;
    logic [31:0] m;
    if (size == 2'b00) begin
      sh = 8 * (3 - int'(addr[1:0]));
      m  = 32'h0000_00FF << sh;
    end else if (size == 2'b01) begin
      sh = addr[1] ? 0 : 16;
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (old & ~m) | ((data << sh) & m);
  endfunction

  function automatic bit ref_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  // Memory responder: acks after the programmed number of wait cycles
  initial begin
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      if (!rst_n || !(bus_if.mem_rd || bus_if.mem_wr)) begin
        wait_cnt = 0;
      end else if (wait_cnt < (bus_if.mem_rd ? rd_dly : wr_dly)) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        bus_if.mem_ack = 1'b1;
        if (bus_if.mem_rd) begin
          bus_if.mem_rdata = peek(bus_if.mem_addr);
          log_q.push_back('{1'b0, bus_if.mem_addr, bus_if.mem_rdata});
        end else begin
          mem[int'(bus_if.mem_addr >> 2)] = bus_if.mem_wdata;
          log_q.push_back('{1'b1, bus_if.mem_addr, bus_if.mem_wdata});
        end
      end
    end
  end

  // Protocol monitor
  initial forever begin
    @(negedge clk);
    if (bus_if.mem_rd && bus_if.mem_wr) overlap++;
    if (bus_if.mem_rd) rd_cycles++;
    if (bus_if.done) done_q.push_back(cyc);
  end

  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] data, input int rdd, input int wrd);
    logic [31:0] waddr, old, exp_word;
    bit bad, word;
    int acc, n, lat, exp_lat, exp_n;
    waddr    = {addr[31:2], 2'b00};
    old      = peek(waddr);
    bad      = ref_bad(size, addr);
    word     = (size == 2'b10);
    exp_word = bad ? old : ref_store(old, size, addr, data);
    exp_lat  = bad ? 1 : (word ? 2 + wrd : 3 + rdd + wrd);
    exp_n    = bad ? 0 : (word ? 1 : 2);
    @(negedge clk);
    n = 0;
    while (!bus_if.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
    rd_dly = rdd; wr_dly = wrd; rd_cycles = 0; log_q.delete();
    bus_if.req_valid = 1'b1;
    bus_if.req_size  = size;
    bus_if.req_addr  = addr;
    bus_if.req_data  = data;
    acc = cyc + 1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_data  = $urandom;
    n = 0;
    while (!(bus_if.done || bus_if.fault) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk({tag, "_resp_timeout"}, 64'd0, 64'd1);
    lat = cyc - acc + 1;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_fault"}, bus_if.fault, bad);
    chk({tag, "_done"}, bus_if.done, !bad);
    if (!bad) chk({tag, "_ready_with_done"}, bus_if.req_ready, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {bus_if.done, bus_if.fault}, 2'b00);
    chk({tag, "_ready_after"}, bus_if.req_ready, 1'b1);
    chk({tag, "_access_count"}, log_q.size(), exp_n);
    if (log_q.size() == exp_n && exp_n > 0) begin
      chk({tag, "_wr_kind"}, log_q[exp_n-1].is_wr, 1'b1);
      chk({tag, "_wr_addr"}, log_q[exp_n-1].addr, waddr);
      chk({tag, "_wr_data"}, log_q[exp_n-1].data, exp_word);
      if (exp_n == 2) begin
        chk({tag, "_rd_kind"}, log_q[0].is_wr, 1'b0);
        chk({tag, "_rd_addr"}, log_q[0].addr, waddr);
      end
    end
    chk({tag, "_rd_cycles"}, rd_cycles, (bad || word) ? 0 : rdd + 1);
    chk({tag, "_mem"}, peek(waddr), exp_word);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0;
    logic [31:0] d0, d1;
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_size  = 2'b00;
    bus_if.req_addr  = 32'h0;
    bus_if.req_data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus_if.req_ready, 1'b1);
    chk("rst_strobes", {bus_if.mem_rd, bus_if.mem_wr}, 2'b00);
    chk("rst_pulses", {bus_if.done, bus_if.fault}, 2'b00);
    chk("rst_addr", bus_if.mem_addr, 32'h0);
    chk("rst_wdata", bus_if.mem_wdata, 32'h0);
    rst_n = 1'b1;

    mem[32'h200 >> 2] = 32'h1122_3344;
    mem[32'h300 >> 2] = 32'h1122_3344;
    do_store("sw_100", 2'b10, 32'h100, 32'hDEAD_BEEF, 0, 0);
    chk("sw_100_value", peek(32'h100), 32'hDEAD_BEEF);
    do_store("sb_203", 2'b00, 32'h203, 32'h0000_00AA, 0, 0);
    chk("sb_203_value", peek(32'h200), 32'h1122_33AA);
    do_store("sh_302", 2'b01, 32'h302, 32'h0000_CAFE, 2, 0);
    chk("sh_302_value", peek(32'h300), 32'h1122_CAFE);
    do_store("flt_sh_101", 2'b01, 32'h101, 32'h1234_5678, 0, 0);
    do_store("flt_sw_102", 2'b10, 32'h102, 32'h1234_5678, 0, 0);
    do_store("flt_ill", 2'b11, 32'h100, 32'h1234_5678, 0, 0);

    // Reset while a write (then a read) is waiting for an ack
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rd_dly = 1000; wr_dly = 1000; log_q.delete();
      n0 = done_q.size();
      bus_if.req_valid = 1'b1;
      bus_if.req_size  = (i == 0) ? 2'b10 : 2'b00;
      bus_if.req_addr  = 32'h500;
      bus_if.req_data  = 32'h0BAD_F00D;
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      chk("rst_mid_strobe", {bus_if.mem_rd, bus_if.mem_wr}, (i == 0) ? 2'b01 : 2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes_low", {bus_if.mem_rd, bus_if.mem_wr}, 2'b00);
      chk("rst_mid_ready", bus_if.req_ready, 1'b1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mid_no_done", done_q.size(), n0);
      chk("rst_mid_no_access", log_q.size(), 0);
    end
    rd_dly = 0; wr_dly = 0;

    // Back-to-back word stores with request held valid
    @(negedge clk);
    d0 = $urandom; d1 = $urandom;
    n0 = done_q.size();
    bus_if.req_valid = 1'b1;
    bus_if.req_size  = 2'b10;
    bus_if.req_addr  = 32'h600;
    bus_if.req_data  = d0;
    @(negedge clk);
    bus_if.req_addr = 32'h604;
    bus_if.req_data = d1;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    n = 0;
    while (!bus_if.done && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("b2b_done_count", done_q.size() - n0, 2);
    if (done_q.size() - n0 == 2) chk("b2b_done_gap", done_q[n0+1] - done_q[n0], 2);
    chk("b2b_mem0", peek(32'h600), d0);
    chk("b2b_mem1", peek(32'h604), d1);

    // Randomized stores over a small address window
    for (int i = 0; i < 60; i++) begin
      do_store($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
               32'h1000 | 32'($urandom_range(0, 255)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
    end

    chk("rd_wr_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
